player_mover: RTL and testbench



---
 rtl/zork_pkg.sv | 6 +
 rtl/move_cooldown_counter.sv | 17 +
 rtl/player_mover.sv | 72 +++++++
 tb/tb_player_mover.sv | 110 +++++++++++
 4 files changed

// File: rtl/zork_pkg.sv
// zork_pkg: shared grid width, direction codes and mover FSM encoding.
package zork_pkg;
  localparam int GRID_W = 4;
  typedef enum logic [1:0] {DIR_N = 2'b00, DIR_S = 2'b01, DIR_E = 2'b10, DIR_W = 2'b11} dir_t;
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_COMMIT, S_BLOCKED, S_COOLDOWN} state_t;
endpackage

// File: rtl/move_cooldown_counter.sv
// move_cooldown_counter: loadable down-counter; done flags the last enabled count.
module move_cooldown_counter #(
  parameter logic [7:0] LOAD_VAL = 8'd4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic done
);
  logic [7:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= LOAD_VAL;
    else if (en && cnt != 8'd0) cnt <= cnt - 8'd1;
  assign done = en && cnt == 8'd1;
endmodule

// File: rtl/player_mover.sv
// player_mover: grid walker with bounds and key-room gating, one move per request plus cooldown.
module player_mover
  import zork_pkg::*;
#(
  parameter logic [GRID_W-1:0] START_X  = 4'd0,
  parameter logic [GRID_W-1:0] START_Y  = 4'd0,
  parameter logic [GRID_W-1:0] GRID_MAX = 4'd15,
  parameter logic [GRID_W-1:0] KEY_X    = 4'd0,
  parameter logic [GRID_W-1:0] KEY_Y    = 4'd6,
  parameter logic [7:0]        COOLDOWN = 8'd4
) (
  input  logic              clk_50MHz_i,
  input  logic              rst_async_ha_i,
  input  logic              move_req_i,
  input  logic [1:0]        dir_i,
  input  logic              can_access_key_i,
  output logic [GRID_W-1:0] posx_o,
  output logic [GRID_W-1:0] posy_o,
  output logic              enable_move_o,
  output logic              blocked_o,
  output logic              move_busy_o,
  output logic              has_key_o
);
  state_t state, next;
  dir_t dir_q;
  logic [GRID_W:0] tx, ty;
  logic at_key, legal, cd_done;
  // one extra bit so 0-1 and GRID_MAX+1 both land above GRID_MAX
  always_comb begin
    tx = {1'b0, posx_o} + (dir_q == DIR_E ? 5'd1 : dir_q == DIR_W ? 5'h1f : 5'd0);
    ty = {1'b0, posy_o} + (dir_q == DIR_N ? 5'd1 : dir_q == DIR_S ? 5'h1f : 5'd0);
    at_key = tx == {1'b0, KEY_X} && ty == {1'b0, KEY_Y};
    legal = tx <= {1'b0, GRID_MAX} && ty <= {1'b0, GRID_MAX} && !(at_key && !can_access_key_i && !has_key_o);
  end
  always_ff @(posedge clk_50MHz_i or posedge rst_async_ha_i)
    if (rst_async_ha_i) begin
      state <= S_IDLE;
      dir_q <= DIR_N;
    end else begin
      state <= next;
      if (state == S_IDLE && move_req_i) dir_q <= dir_t'(dir_i);
    end
  always_comb
    next = state == S_IDLE ? (move_req_i ? S_CHECK : S_IDLE) :
           state == S_CHECK ? (legal ? S_COMMIT : S_BLOCKED) :
           state == S_COOLDOWN ? (cd_done ? S_IDLE : S_COOLDOWN) : S_COOLDOWN;
  always_ff @(posedge clk_50MHz_i or posedge rst_async_ha_i)
    if (rst_async_ha_i) begin
      posx_o <= START_X;
      posy_o <= START_Y;
      enable_move_o <= 1'b0;
      blocked_o <= 1'b0;
      move_busy_o <= 1'b0;
      has_key_o <= 1'b0;
    end else begin
      enable_move_o <= state == S_CHECK && legal;
      blocked_o <= state == S_CHECK && !legal;
      move_busy_o <= next != S_IDLE;
      if (state == S_CHECK && legal) begin
        posx_o <= tx[GRID_W-1:0];
        posy_o <= ty[GRID_W-1:0];
        if (at_key) has_key_o <= 1'b1;
      end
    end
  move_cooldown_counter #(.LOAD_VAL(COOLDOWN)) u_cd (
    .clk(clk_50MHz_i),
    .rst(rst_async_ha_i),
    .load(state == S_COMMIT || state == S_BLOCKED),
    .en(state == S_COOLDOWN),
    .done(cd_done)
  );
endmodule

// File: tb/tb_player_mover.sv
// tb_player_mover: directed moves through bounds, key room, held requests and mid-move reset.
module tb_player_mover;
  logic clk = 1'b0, rst = 1'b1, req = 1'b0, can = 1'b0;
  logic [1:0] dir = 2'b00;
  logic [3:0] posx, posy;
  logic en, blk, busy, key;
  int compared = 0, mismatched = 0;
  int en_n, blk_n, busy_n, lat, first, second;
  always #10 clk = ~clk;
  player_mover dut (
    .clk_50MHz_i(clk), .rst_async_ha_i(rst), .move_req_i(req), .dir_i(dir),
    .can_access_key_i(can), .posx_o(posx), .posy_o(posy), .enable_move_o(en),
    .blocked_o(blk), .move_busy_o(busy), .has_key_o(key)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic do_move(input logic [1:0] d);
    req = 1'b1;
    dir = d;
    en_n = 0; blk_n = 0; busy_n = 0; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) req = 1'b0;
      if (en) begin en_n++; if (lat == 0) lat = i; end
      if (blk) blk_n++;
      if (busy) busy_n++; else break;
    end
    chk("move_settled", busy, 0);
  endtask
  task automatic go(input logic [1:0] d, input int n);
    for (int k = 0; k < n; k++) do_move(d);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_x", posx, 0); chk("rst_y", posy, 0); chk("rst_en", en, 0);
    chk("rst_blk", blk, 0); chk("rst_busy", busy, 0); chk("rst_key", key, 0);
    rst = 1'b0;
    @(negedge clk);
    do_move(2'b00);
    chk("n_y", posy, 1); chk("n_en", en_n, 1); chk("n_lat", lat, 2);
    chk("n_busy", busy_n, 6); chk("n_blk", blk_n, 0);
    do_move(2'b01);
    chk("s_y", posy, 0);
    do_move(2'b11);
    chk("w_blk", blk_n, 1); chk("w_en", en_n, 0); chk("w_x", posx, 0); chk("w_y", posy, 0);
    do_move(2'b01);
    chk("s0_blk", blk_n, 1); chk("s0_y", posy, 0);
    go(2'b00, 3); go(2'b10, 15);
    chk("far_x", posx, 15); chk("far_y", posy, 3);
    do_move(2'b10);
    chk("e_blk", blk_n, 1); chk("e_en", en_n, 0); chk("e_x", posx, 15);
    go(2'b11, 14); go(2'b00, 3);
    chk("pre_key_x", posx, 1); chk("pre_key_y", posy, 6);
    do_move(2'b11);
    chk("key_shut_blk", blk_n, 1); chk("key_shut_x", posx, 1); chk("key_shut_key", key, 0);
    can = 1'b1;
    do_move(2'b11);
    chk("key_open_en", en_n, 1); chk("key_open_x", posx, 0); chk("key_open_y", posy, 6);
    chk("key_set", key, 1);
    can = 1'b0;
    do_move(2'b10);
    chk("leave_en", en_n, 1); chk("leave_x", posx, 1);
    do_move(2'b11);
    chk("return_en", en_n, 1); chk("return_blk", blk_n, 0); chk("return_x", posx, 0);
    go(2'b01, 4); go(2'b10, 2);
    chk("hold_start_x", posx, 2); chk("hold_start_y", posy, 2);
    req = 1'b1; dir = 2'b10; en_n = 0; first = 0; second = 0;
    for (int i = 1; i <= 21; i++) begin
      @(negedge clk);
      if (en) begin
        en_n++;
        if (first == 0) first = i; else if (second == 0) second = i;
      end
    end
    req = 1'b0;
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    chk("hold_settled", busy, 0);
    chk("hold_moves", en_n, 3); chk("hold_first", first, 2);
    chk("hold_period", second - first, 7); chk("hold_x", posx, 5);
    do_move(2'b11);
    chk("pre_rst_x", posx, 4);
    req = 1'b1; dir = 2'b11;
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    chk("mid_x", posx, 3); chk("mid_en", en, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_x", posx, 0); chk("arst_y", posy, 0); chk("arst_key", key, 0);
    chk("arst_busy", busy, 0); chk("arst_en", en, 0); chk("arst_blk", blk, 0);
    en_n = 0; blk_n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (en) en_n++;
      if (blk) blk_n++;
    end
    chk("rst_hold_pulses", en_n + blk_n, 0);
    rst = 1'b0;
    do_move(2'b00);
    chk("post_rst_lat", lat, 2); chk("post_rst_en", en_n, 1); chk("post_rst_y", posy, 1);
    chk("post_rst_x", posx, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
